snake_step_sched: RTL

- Game-level controller that sequences the snake move engine.
- Generates paced step requests and arbitrates the four direction buttons into one committed heading per step, rejecting reversals.
- Runs the IDLE/RUN/PAUSE/OVER game flow from collision and food reports returned with each step acknowledge.
- Sits between the board buttons and the move engine; the 8x8 LED scan path is untouched.

---
 rtl/snake_pkg.sv | 23 ++
 rtl/snake_dir_arb.sv | 51 +++++
 rtl/snake_step_sched.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake step scheduler: game states, heading codes and
// the reversal test used by the direction arbiter.
package snake_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_PAUSE    = 3'd3,
        ST_OVER     = 3'd4
    } state_e;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Opposite headings are bitwise complements (left/right, down/up).
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a == (b ^ 2'b11));
    endfunction

endpackage

// File: rtl/snake_dir_arb.sv
// Direction arbiter: picks the highest-priority pressed button that is not a
// reversal of the committed heading and keeps it in the pending register.
module snake_dir_arb
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       clear_n,
    input  logic       i_en,
    input  logic       i_load,
    input  logic [1:0] i_load_dir,
    input  logic [3:0] i_btn,
    input  logic [1:0] i_committed,
    output logic [1:0] o_pending
);

    logic [1:0] r_pending;
    logic [1:0] w_pick;
    logic       w_valid;

    // Button bits [3]=right [0]=left [1]=down [2]=up, tried in that order.
    always_comb begin
        w_valid = 1'b0;
        w_pick  = r_pending;
        if (i_btn[3] && !is_reverse(DIR_RIGHT, i_committed)) begin
            w_valid = 1'b1;
            w_pick  = DIR_RIGHT;
        end else if (i_btn[0] && !is_reverse(DIR_LEFT, i_committed)) begin
            w_valid = 1'b1;
            w_pick  = DIR_LEFT;
        end else if (i_btn[1] && !is_reverse(DIR_DOWN, i_committed)) begin
            w_valid = 1'b1;
            w_pick  = DIR_DOWN;
        end else if (i_btn[2] && !is_reverse(DIR_UP, i_committed)) begin
            w_valid = 1'b1;
            w_pick  = DIR_UP;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_pending <= DIR_RIGHT;
        end else if (i_load) begin
            r_pending <= i_load_dir;
        end else if (i_en && w_valid) begin
            r_pending <= w_pick;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/snake_step_sched.sv
// Game-level step scheduler: paces step requests to the move engine, commits a
// heading per step and runs the IDLE/RUN/PAUSE/OVER flow. SNAKE_SPEEDUP_EN
// enables shortening the step period on every food eaten.
module snake_step_sched
    import snake_pkg::*;
#(
    parameter int TICK_DIV    = 10000000,
    parameter int MIN_DIV     = 2000000,
    parameter int DIV_STEP    = 500000,
    parameter int SCORE_W     = 8,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic [3:0]         btn_dir,
    input  logic               btn_start,
    input  logic               btn_pause,
    output logic               step_req,
    output logic [1:0]         step_dir,
    input  logic               step_ack,
    input  logic               hit_wall,
    input  logic               hit_self,
    input  logic               ate_food,
    output logic               engine_init,
    output logic [2:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic               fault
);

    localparam int CNT_W  = $clog2(TICK_DIV + 1);
    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  P_TICK    = CNT_W'(TICK_DIV);
    localparam logic [CNT_W-1:0]  P_MIN     = CNT_W'(MIN_DIV);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
`ifdef SNAKE_SPEEDUP_EN
    localparam logic [CNT_W-1:0]  P_STEP    = CNT_W'(DIV_STEP);
`else
    // Zero decrement keeps the period at TICK_DIV for the whole game.
    localparam logic [CNT_W-1:0]  P_STEP    = CNT_W'(DIV_STEP * 0);
`endif

    state_e             r_state, nxt_state;
    logic [CNT_W-1:0]   r_tick, nxt_tick;
    logic [CNT_W-1:0]   r_period, nxt_period;
    logic [WAIT_W-1:0]  r_wait, nxt_wait;
    logic               r_step_req, nxt_req;
    logic [1:0]         r_step_dir, nxt_dir;
    logic               r_init, nxt_init;
    logic [SCORE_W-1:0] r_score, nxt_score;
    logic               r_fault, nxt_fault;
    logic               r_pause_pend, nxt_pause_pend;
    logic               r_start_q, r_pause_q;

    logic               w_start_edge, w_pause_edge;
    logic               w_tick_last, w_restart, w_arb_en;
    logic [1:0]         w_pending;
    logic [CNT_W-1:0]   w_period_eat;

    assign w_start_edge = btn_start & ~r_start_q;
    assign w_pause_edge = btn_pause & ~r_pause_q;
    assign w_tick_last  = (r_tick == (r_period - 1'b1));
    assign w_arb_en     = (r_state == ST_RUN) || (r_state == ST_WAIT_ACK) ||
                          (r_state == ST_PAUSE);

    // Saturating decrement toward the floor, compared one bit wider to avoid wrap.
    assign w_period_eat = ({1'b0, r_period} >= ({1'b0, P_MIN} + {1'b0, P_STEP})) ?
                          (r_period - P_STEP) : P_MIN;

    snake_dir_arb u_dir_arb (
        .clk         (clk),
        .clear_n     (clear_n),
        .i_en        (w_arb_en),
        .i_load      (w_restart),
        .i_load_dir  (DIR_RIGHT),
        .i_btn       (btn_dir),
        .i_committed (r_step_dir),
        .o_pending   (w_pending)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state      <= ST_IDLE;
            r_tick       <= '0;
            r_period     <= P_TICK;
            r_wait       <= '0;
            r_step_req   <= 1'b0;
            r_step_dir   <= DIR_RIGHT;
            r_init       <= 1'b0;
            r_score      <= '0;
            r_fault      <= 1'b0;
            r_pause_pend <= 1'b0;
            r_start_q    <= 1'b0;
            r_pause_q    <= 1'b0;
        end else begin
            r_state      <= nxt_state;
            r_tick       <= nxt_tick;
            r_period     <= nxt_period;
            r_wait       <= nxt_wait;
            r_step_req   <= nxt_req;
            r_step_dir   <= nxt_dir;
            r_init       <= nxt_init;
            r_score      <= nxt_score;
            r_fault      <= nxt_fault;
            r_pause_pend <= nxt_pause_pend;
            r_start_q    <= btn_start;
            r_pause_q    <= btn_pause;
        end
    end

    always_comb begin
        nxt_state      = r_state;
        nxt_tick       = r_tick;
        nxt_period     = r_period;
        nxt_wait       = r_wait;
        nxt_req        = r_step_req;
        nxt_dir        = r_step_dir;
        nxt_init       = 1'b0;
        nxt_score      = r_score;
        nxt_fault      = r_fault;
        nxt_pause_pend = r_pause_pend;
        w_restart      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) w_restart = 1'b1;
            end
            ST_RUN: begin
                if (w_pause_edge) begin
                    nxt_state = ST_PAUSE;
                end else if (w_tick_last) begin
                    nxt_tick       = '0;
                    nxt_dir        = w_pending;
                    nxt_req        = 1'b1;
                    nxt_wait       = '0;
                    nxt_pause_pend = 1'b0;
                    nxt_state      = ST_WAIT_ACK;
                end else begin
                    nxt_tick = r_tick + 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                if (w_pause_edge) nxt_pause_pend = 1'b1;
                if (step_ack) begin
                    nxt_req        = 1'b0;
                    nxt_pause_pend = 1'b0;
                    if (hit_wall || hit_self) begin
                        nxt_state = ST_OVER;
                    end else begin
                        if (ate_food) begin
                            if (r_score != '1) nxt_score = r_score + 1'b1;
                            nxt_period = w_period_eat;
                        end
                        nxt_state = (r_pause_pend || w_pause_edge) ? ST_PAUSE : ST_RUN;
                    end
                end else if (r_wait == WAIT_LAST) begin
                    nxt_fault      = 1'b1;
                    nxt_req        = 1'b0;
                    nxt_pause_pend = 1'b0;
                    nxt_state      = ST_OVER;
                end else begin
                    nxt_wait = r_wait + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (w_start_edge)      w_restart = 1'b1;
                else if (w_pause_edge) nxt_state = ST_RUN;
            end
            ST_OVER: begin
                if (w_start_edge) w_restart = 1'b1;
            end
            default: nxt_state = ST_IDLE;
        endcase

        // A fresh game: engine reinit, counters reloaded, heading back to right.
        if (w_restart) begin
            nxt_state      = ST_RUN;
            nxt_init       = 1'b1;
            nxt_score      = '0;
            nxt_tick       = '0;
            nxt_period     = P_TICK;
            nxt_dir        = DIR_RIGHT;
            nxt_req        = 1'b0;
            nxt_fault      = 1'b0;
            nxt_pause_pend = 1'b0;
        end
    end

    assign step_req    = r_step_req;
    assign step_dir    = r_step_dir;
    assign engine_init = r_init;
    assign state       = r_state;
    assign score       = r_score;
    assign fault       = r_fault;

endmodule
